// File: rtl/awgn_sweep_ctrl.sv
// awgn_sweep_ctrl: steps an AWGN channel model through a range of SNR points.
// For each point it loads the noise sigma, streams frame_len source samples
// into the channel, then flushes the channel for DRAIN_CYC cycles.
// Optional build macro: AWGN_SWEEP_ERRCNT_EN adds the ref_bit input and the
// err_cnt output, which count sign errors on the channel output.
module awgn_sweep_ctrl #(
    parameter int DW        = 24,
    parameter int DRAIN_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    snr_lo,
    input  logic [3:0]    snr_hi,
    input  logic [15:0]   frame_len,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          ch_read,
    output logic [DW-1:0] ch_data,
    output logic [7:0]    ch_sigma,
    output logic          ch_reset,
    input  logic [DW-1:0] ch_y,
    input  logic          ch_y_valid,
    output logic [3:0]    snr_cur,
    output logic          busy,
    output logic          point_done,
    output logic          sweep_done
`ifdef AWGN_SWEEP_ERRCNT_EN
    ,
    input  logic          ref_bit,
    output logic [15:0]   err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_RUN, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_snr_cur;
    logic [3:0]      r_snr_end;
    logic [15:0]     r_flen;
    logic [15:0]     r_cnt;
    logic [DCW-1:0]  r_drain;
    logic [DW-1:0]   r_ch_data;
    logic            r_ch_read;
    logic [7:0]      r_ch_sigma;
    logic            r_rst_seen;

    logic            w_src_ready;
    logic            w_accept;
    logic            w_point_done;
    logic            w_sweep_done;
    logic            w_busy;
    logic            w_ch_reset;
    logic            w_unused;

    // SNR points above 9 dB are not in the sigma table; pin them to 9.
    function automatic logic [3:0] f_clamp(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Noise sigma per SNR point (0..9 dB).
    function automatic logic [7:0] f_sigma(input logic [3:0] snr);
        logic [7:0] s;
        case (snr)
            4'd0:    s = 8'd180;
            4'd1:    s = 8'd161;
            4'd2:    s = 8'd143;
            4'd3:    s = 8'd128;
            4'd4:    s = 8'd114;
            4'd5:    s = 8'd102;
            4'd6:    s = 8'd90;
            4'd7:    s = 8'd81;
            4'd8:    s = 8'd72;
            default: s = 8'd64;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything, including start.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_CFG;
                S_CFG:   w_state_nxt = S_RUN;
                // r_cnt reaches r_flen on the cycle after the last accept, so the
                // final ch_read pulse still lands inside RUN.
                S_RUN:   if (r_cnt >= r_flen) w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_drain == DRAIN_LAST) w_state_nxt = S_NEXT;
                S_NEXT:  w_state_nxt = (r_snr_cur >= r_snr_end) ? S_DONE : S_CFG;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs; abort masks the handshake and the done pulses.
    always_comb begin
        w_src_ready  = 1'b0;
        w_point_done = 1'b0;
        w_sweep_done = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_ch_reset   = r_rst_seen;
        case (r_state)
            S_CFG:   w_ch_reset   = 1'b1;
            S_RUN:   w_src_ready  = (r_cnt < r_flen) && !abort;
            S_NEXT:  w_point_done = !abort;
            S_DONE:  w_sweep_done = !abort;
            default: ;
        endcase
    end

    assign w_accept = src_valid & w_src_ready;

    // Sweep bookkeeping and the registered channel drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snr_cur  <= 4'd0;
            r_snr_end  <= 4'd0;
            r_flen     <= 16'd0;
            r_cnt      <= 16'd0;
            r_ch_data  <= '0;
            r_ch_read  <= 1'b0;
            r_ch_sigma <= 8'd180;
            r_rst_seen <= 1'b1;
        end else begin
            r_rst_seen <= 1'b0;
            r_ch_read  <= w_accept;
            if (w_accept) begin
                r_ch_data <= src_data;
                r_cnt     <= r_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: if (start && !abort) begin
                    r_snr_cur <= f_clamp(snr_lo);
                    r_snr_end <= f_clamp(snr_hi);
                    r_flen    <= frame_len;
                end
                S_CFG: begin
                    r_ch_sigma <= f_sigma(r_snr_cur);
                    r_cnt      <= 16'd0;
                end
                S_NEXT: if (!abort && (r_snr_cur < r_snr_end)) begin
                    r_snr_cur <= r_snr_cur + 4'd1;
                    r_cnt     <= 16'd0;
                end
                default: ;
            endcase
        end
    end

    // Flush-cycle counter, only live while draining.
    always_ff @(posedge clk) begin
        if (!reset || (r_state != S_DRAIN)) r_drain <= '0;
        else                                r_drain <= r_drain + DCW'(1);
    end

`ifdef AWGN_SWEEP_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Sign-error counter: counts while the channel is fed or flushing,
    // restarts at each point, saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset || (r_state == S_CFG)) begin
            r_err_cnt <= 16'd0;
        end else if ((r_state == S_RUN || r_state == S_DRAIN) && ch_y_valid &&
                     (ch_y[DW-1] != ref_bit) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    // Channel output bits not consumed by this block.
    assign w_unused = ^{ch_y, ch_y_valid};

    assign src_ready  = w_src_ready;
    assign ch_read    = r_ch_read;
    assign ch_data    = r_ch_data;
    assign ch_sigma   = r_ch_sigma;
    assign ch_reset   = w_ch_reset;
    assign snr_cur    = r_snr_cur;
    assign busy       = w_busy;
    assign point_done = w_point_done;
    assign sweep_done = w_sweep_done;

endmodule

// File: tb/tb_awgn_sweep_ctrl.sv
// tb_awgn_sweep_ctrl: self-checking bench for awgn_sweep_ctrl.
// Expected sweep behaviour comes from a point-list model (clamped lo..hi,
// sigma table, frame_len reads per point, fixed flush length).
module tb_awgn_sweep_ctrl;
    localparam int DW    = 24;
    localparam int DRAIN = 4;
    typedef logic [DW-1:0] dat_t;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [3:0]    snr_lo, snr_hi;
    logic [15:0]   frame_len;
    logic          src_valid;
    dat_t          src_data;
    logic          src_ready, ch_read, ch_reset;
    dat_t          ch_data;
    logic [7:0]    ch_sigma;
    dat_t          ch_y;
    logic          ch_y_valid;
    logic [3:0]    snr_cur;
    logic          busy, point_done, sweep_done;
`ifdef AWGN_SWEEP_ERRCNT_EN
    logic          ref_bit;
    logic [15:0]   err_cnt;
`endif

    awgn_sweep_ctrl #(.DW(DW), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .snr_lo(snr_lo), .snr_hi(snr_hi), .frame_len(frame_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .ch_read(ch_read), .ch_data(ch_data), .ch_sigma(ch_sigma),
        .ch_reset(ch_reset), .ch_y(ch_y), .ch_y_valid(ch_y_valid),
        .snr_cur(snr_cur), .busy(busy), .point_done(point_done),
        .sweep_done(sweep_done)
`ifdef AWGN_SWEEP_ERRCNT_EN
        , .ref_bit(ref_bit), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int sig_tab[10] = '{180, 161, 143, 128, 114, 102, 90, 81, 72, 64};

    // Observations from one sweep, indexed by cycle number since start.
    dat_t acc_d[$];
    dat_t rd_d[$];
    int   acc_c[$], rd_c[$], cfg_c[$], pd_c[$], pd_sig[$], pd_snr[$];
    int   n_sd;
    bit   tmo;

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Launch a sweep and record what comes out until sweep_done (bounded).
    // mode 0: src_valid always 1; 1: toggles 1,0,1,0; 2: random.
    task automatic run_sweep(input int lo, input int hi, input int flen, input int mode);
        acc_d.delete(); rd_d.delete(); acc_c.delete(); rd_c.delete();
        cfg_c.delete(); pd_c.delete(); pd_sig.delete(); pd_snr.delete();
        n_sd = 0; tmo = 1'b1;
        snr_lo = 4'(lo); snr_hi = 4'(hi); frame_len = 16'(flen);
        src_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            case (mode)
                0:       src_valid = 1'b1;
                1:       src_valid = (c % 2 == 0);
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            src_data = dat_t'($urandom);
            @(negedge clk);
            if (src_valid && src_ready) begin acc_d.push_back(src_data); acc_c.push_back(c); end
            if (ch_read) begin rd_d.push_back(ch_data); rd_c.push_back(c); end
            if (ch_reset && busy) cfg_c.push_back(c);
            if (point_done) begin
                pd_c.push_back(c); pd_sig.push_back(int'(ch_sigma)); pd_snr.push_back(int'(snr_cur));
            end
            if (sweep_done) begin n_sd++; tmo = 1'b0; end
            step();
            if (!tmo) break;
        end
        src_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || snr_cur !== 4'd0 || ch_data !== '0 || ch_sigma !== 8'd180 ||
            ch_reset !== 1'b1 || src_ready !== 1'b0 || ch_read !== 1'b0 ||
            point_done !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b snr=%0d data=%0h sigma=%0d chrst=%0b rdy=%0b rd=%0b pd=%0b sd=%0b, want 0 0 0 180 1 0 0 0 0",
                     busy, snr_cur, ch_data, ch_sigma, ch_reset, src_ready, ch_read, point_done, sweep_done);
        end
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        n_chk++;
        if (ch_reset !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ch_reset=%0b busy=%0b, want 0 0", ch_reset, busy);
        end
        step();
    endtask

    task automatic test_two_points;
        run_sweep(8, 9, 3, 0);
        n_chk++;
        if (tmo || n_sd !== 1 || pd_c.size() !== 2) begin
            n_fail++;
            $display("FAIL two_pt_count: sweep_done=%0d point_done=%0d timeout=%0b, want 1 2 0", n_sd, pd_c.size(), tmo);
        end else begin
            n_chk++;
            if (pd_sig[0] !== 72 || pd_sig[1] !== 64) begin
                n_fail++;
                $display("FAIL two_pt_sigma: got %0d,%0d want 72,64", pd_sig[0], pd_sig[1]);
            end
            n_chk++;
            if (rd_c.size() !== 6 || cfg_c.size() !== 2 || rd_c[2] > pd_c[0] || rd_c[3] < pd_c[0]) begin
                n_fail++;
                $display("FAIL two_pt_reads: total=%0d cfg=%0d, want 6 reads split 3/3 over 2 points", rd_c.size(), cfg_c.size());
            end
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL two_pt_idle: busy=%0b want 0", busy);
        end
        step();
    endtask

    task automatic test_zero_len;
        run_sweep(5, 5, 0, 0);
        n_chk++;
        if (tmo || n_sd !== 1 || pd_c.size() !== 1 || cfg_c.size() !== 1 || rd_c.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_len_count: sd=%0d pd=%0d cfg=%0d reads=%0d, want 1 1 1 0", n_sd, pd_c.size(), cfg_c.size(), rd_c.size());
        end else begin
            n_chk++;
            if (pd_sig[0] !== 102) begin
                n_fail++;
                $display("FAIL zero_len_sigma: got %0d want 102", pd_sig[0]);
            end
            // one RUN cycle sees the empty frame, then the flush
            n_chk++;
            if (pd_c[0] - cfg_c[0] - 1 !== DRAIN + 1) begin
                n_fail++;
                $display("FAIL zero_len_drain: got %0d cycles between CFG and point_done want %0d", pd_c[0] - cfg_c[0] - 1, DRAIN + 1);
            end
        end
    endtask

    task automatic test_clamp;
        run_sweep(12, 15, 2, 0);
        n_chk++;
        if (tmo || pd_c.size() !== 1 || pd_snr[0] !== 9 || pd_sig[0] !== 64) begin
            n_fail++;
            $display("FAIL clamp_hi: points=%0d snr=%0d sigma=%0d, want 1 9 64", pd_c.size(),
                     pd_snr.size() ? pd_snr[0] : -1, pd_sig.size() ? pd_sig[0] : -1);
        end
        run_sweep(7, 3, 1, 0);
        n_chk++;
        if (tmo || pd_c.size() !== 1 || pd_snr[0] !== 7 || pd_sig[0] !== 81 || rd_c.size() !== 1) begin
            n_fail++;
            $display("FAIL lo_gt_hi: points=%0d reads=%0d, want single point at 7 dB sigma 81 with 1 read", pd_c.size(), rd_c.size());
        end
    endtask

    task automatic test_toggle;
        run_sweep(2, 2, 2, 1);
        n_chk++;
        if (tmo || acc_c.size() !== 2 || rd_c.size() !== 2) begin
            n_fail++;
            $display("FAIL toggle_count: accepts=%0d reads=%0d want 2 2", acc_c.size(), rd_c.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (rd_c[k] !== acc_c[k] + 1 || rd_d[k] !== acc_d[k]) begin
                    n_fail++;
                    $display("FAIL toggle_read%0d: cycle %0d data %0h, want cycle %0d data %0h", k, rd_c[k], rd_d[k], acc_c[k] + 1, acc_d[k]);
                end
            end
        end
    endtask

    task automatic test_abort;
        int nacc = 0;
        int ndone = 0;
        bit got = 1'b0;
        snr_lo = 4'd3; snr_hi = 4'd3; frame_len = 16'd10;
        start = 1'b1; step(); start = 1'b0;
        src_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            src_data = dat_t'($urandom);
            @(negedge clk);
            if (src_valid && src_ready) nacc++;
            step();
            if (nacc == 2) begin got = 1'b1; break; end
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL abort_setup: accepts=%0d want 2", nacc);
        end
        abort = 1'b1;
        @(negedge clk);
        n_chk++;
        if (src_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: src_ready=%0b want 0", src_ready);
        end
        step();
        abort = 1'b0; src_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || ch_read !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%0b ch_read=%0b want 0 0", busy, ch_read);
        end
        for (int c = 0; c < 8; c++) begin
            if (point_done || sweep_done) ndone++;
            step(); @(negedge clk);
        end
        n_chk++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d done pulses want 0", ndone);
        end
        step();
        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_priority: busy=%0b want 0", busy);
        end
        step();
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || ch_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: busy=%0b ch_reset=%0b want 1 1 (CFG)", busy, ch_reset);
        end
        step();
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_reset_midrun;
        bit seen = 1'b0;
        snr_lo = 4'd0; snr_hi = 4'd0; frame_len = 16'd5;
        start = 1'b1; step(); start = 1'b0;
        src_valid = 1'b1; src_data = dat_t'($urandom);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (src_ready) begin seen = 1'b1; break; end
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1; src_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (!seen || ch_read !== 1'b0 || busy !== 1'b0 || ch_data !== '0 || ch_sigma !== 8'd180) begin
            n_fail++;
            $display("FAIL reset_midrun: ready_seen=%0b ch_read=%0b busy=%0b data=%0h sigma=%0d, want 1 0 0 0 180",
                     seen, ch_read, busy, ch_data, ch_sigma);
        end
        step();
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int lo, hi, fl, lc, hc, np, nread, last;
            lo = $urandom_range(0, 15); hi = $urandom_range(0, 15); fl = $urandom_range(0, 6);
            run_sweep(lo, hi, fl, 2);
            lc = (lo > 9) ? 9 : lo;
            hc = (hi > 9) ? 9 : hi;
            np = (hc > lc) ? hc - lc + 1 : 1;
            n_chk++;
            if (tmo || n_sd !== 1 || pd_c.size() !== np || cfg_c.size() !== np) begin
                n_fail++;
                $display("FAIL rnd%0d_points: lo=%0d hi=%0d sd=%0d pd=%0d cfg=%0d, want 1 %0d %0d", it, lo, hi, n_sd, pd_c.size(), cfg_c.size(), np, np);
                continue;
            end
            for (int i = 0; i < np; i++) begin
                n_chk++;
                if (pd_snr[i] !== lc + i || pd_sig[i] !== sig_tab[lc + i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_pt%0d: snr=%0d sigma=%0d want %0d %0d", it, i, pd_snr[i], pd_sig[i], lc + i, sig_tab[lc + i]);
                end
                nread = 0;
                last = cfg_c[i] + 1;
                foreach (rd_c[k]) if (rd_c[k] > cfg_c[i] && rd_c[k] < pd_c[i]) begin nread++; last = rd_c[k]; end
                n_chk++;
                if (nread !== fl || pd_c[i] - last - 1 !== DRAIN) begin
                    n_fail++;
                    $display("FAIL rnd%0d_pt%0d_frame: reads=%0d flush=%0d want %0d %0d", it, i, nread, pd_c[i] - last - 1, fl, DRAIN);
                end
            end
            n_chk++;
            if (rd_d.size() !== acc_d.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_accepts: reads=%0d accepts=%0d", it, rd_d.size(), acc_d.size());
            end else begin
                foreach (rd_d[k]) begin
                    n_chk++;
                    if (rd_d[k] !== acc_d[k] || rd_c[k] !== acc_c[k] + 1) begin
                        n_fail++;
                        $display("FAIL rnd%0d_read%0d: data %0h at %0d, want %0h at %0d", it, k, rd_d[k], rd_c[k], acc_d[k], acc_c[k] + 1);
                    end
                end
            end
        end
    endtask

`ifdef AWGN_SWEEP_ERRCNT_EN
    task automatic test_errcnt;
        bit mism[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int exp_err = 0;
        snr_lo = 4'd1; snr_hi = 4'd1; frame_len = 16'd8; src_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            ref_bit = 1'($urandom_range(0, 1));
            ch_y = dat_t'($urandom);
            ch_y[DW-1] = ref_bit ^ mism[i];
            ch_y_valid = 1'b1;
            if (mism[i]) exp_err++;
            step();
        end
        ch_y_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (err_cnt !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL errcnt_count: got %0d want %0d", err_cnt, exp_err);
        end
        step();
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        @(negedge clk);
        n_chk++;
        if (err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL errcnt_clear: got %0d want 0", err_cnt);
        end
        step();
        abort = 1'b1; step(); abort = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        snr_lo = 4'd0; snr_hi = 4'd0; frame_len = 16'd0;
        src_valid = 1'b0; src_data = '0; ch_y = '0; ch_y_valid = 1'b0;
`ifdef AWGN_SWEEP_ERRCNT_EN
        ref_bit = 1'b0;
`endif
        test_reset();
        test_two_points();
        test_zero_len();
        test_clamp();
        test_toggle();
        test_abort();
        test_reset_midrun();
        test_random();
`ifdef AWGN_SWEEP_ERRCNT_EN
        test_errcnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/awgn_sweep_ctrl.md
AWGN_SWEEP_CTRL -- requirements
Module: awgn_sweep_ctrl

Interface
REQ-001 SHALL have parameters: DW, default 24, sample width; DRAIN_CYC, default 4, channel flush cycles per SNR point.
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  sweep request pulse.
REQ-005 SHALL have port abort  input  1  terminate sweep.
REQ-006 SHALL have ports snr_lo, snr_hi  input  4 each  first/last SNR point in dB.
REQ-007 SHALL have port frame_len  input  16  samples per SNR point.
REQ-008 SHALL have ports src_valid  input  1, src_data  input  DW, src_ready  output  1  source handshake.
REQ-009 SHALL have ports ch_read  output  1, ch_data  output  DW, ch_sigma  output  8, ch_reset  output  1 (active-high)  channel drive.
REQ-010 SHALL have ports ch_y  input  DW, ch_y_valid  input  1  channel output.
REQ-011 SHALL have ports snr_cur  output  4, busy  output  1, point_done  output  1, sweep_done  output  1  status.

Function
REQ-012 SHALL implement FSM IDLE, CFG, RUN, DRAIN, NEXT, DONE.
REQ-013 IDLE: start=1 -> CFG; snr_cur<=min(snr_lo,9); start in any other state ignored.
REQ-014 CFG (1 cycle): ch_reset=1; ch_sigma<=table[snr_cur] = 180,161,143,128,114,102,90,81,72,64 for 0..9 dB; -> RUN.
REQ-015 RUN: src_ready=1 while sample count < frame_len; each src_valid&src_ready registers src_data into ch_data and pulses ch_read=1 the following cycle (latency 1).
REQ-016 RUN: 16-bit counter increments per accepted sample; on count==frame_len after last accept -> DRAIN; frame_len=0 -> DRAIN immediately, no ch_read.
REQ-017 DRAIN: exactly DRAIN_CYC cycles, src_ready=0, ch_read=0; -> NEXT.
REQ-018 NEXT (1 cycle): point_done=1; if snr_cur>=min(snr_hi,9) -> DONE, else snr_cur+1, counter cleared -> CFG.
REQ-019 snr_lo>snr_hi SHALL run a single point at snr_lo; values >9 clamp to 9.
REQ-020 DONE (1 cycle): sweep_done=1 -> IDLE.
REQ-021 abort=1 in any state SHALL force IDLE next cycle with no point_done/sweep_done; abort takes priority over start.
REQ-022 busy=1 in every state except IDLE.
REQ-023 ch_y/ch_y_valid are observed only by the error-count feature; otherwise unused.

Reset
REQ-024 reset=0 at a clock edge SHALL force IDLE, snr_cur=0, counter=0, ch_data=0, ch_sigma=180, ch_reset=1, all other outputs 0.
REQ-025 reset asserted mid-RUN SHALL discard the in-flight sample; no ch_read on the following cycle.
REQ-026 ch_reset SHALL be 0 in IDLE after reset release, 1 only in CFG.

Configuration
REQ-027 Macro AWGN_SWEEP_ERRCNT_EN SHALL add input ref_bit (1) and output err_cnt (16).
REQ-028 With macro: on each ch_y_valid, err_cnt increments when ch_y[DW-1] != ref_bit, saturating at 65535; cleared in CFG; held in NEXT/DONE/IDLE.
REQ-029 Without macro: ports ref_bit and err_cnt absent, no comparator or counter logic.

Verification
REQ-030 snr_lo=8, snr_hi=9, frame_len=3, src_valid=1 -> ch_sigma 72 then 64, 3 ch_read per point, 2 point_done, 1 sweep_done.
REQ-031 frame_len=0, snr_lo=snr_hi=5 -> ch_sigma=102, zero ch_read, DRAIN 4 cycles, point_done, sweep_done.
REQ-032 snr_lo=12, snr_hi=15 -> single point, snr_cur=9, ch_sigma=64.
REQ-033 abort during RUN after 2 of 10 samples -> IDLE next cycle, busy=0, no done pulses; start then restarts from CFG.
REQ-034 src_valid toggling 1,0,1,0 with frame_len=2 -> ch_read exactly one cycle after each accepted sample, ch_data matches.
REQ-035 With AWGN_SWEEP_ERRCNT_EN, 4 ch_y_valid with sign mismatches on 2 -> err_cnt=2, cleared to 0 at next CFG.
